// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral register bank with parametrised register count and width.
// Frame: R/W bit (1 = write), ADDR_W-bit start address, then DATA_W-bit words, MSB first.
// Writes commit per word; reads shift the addressed register out on CIPO.
// Build option SPI_BURST_EN: when defined, words auto-increment the address without limit;
// when undefined, exactly one data word is handled per frame.
module spi_reg_bank #(
  parameter int unsigned NUM_REGS = 9,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         nCS,
  input  logic                         SCLK,
  input  logic                         COPI,
  output logic                         CIPO,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         busy
);

  localparam int unsigned HdrBits = ADDR_W + 1;
  localparam int unsigned HW      = $clog2(HdrBits + 1);
  localparam int unsigned BW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  // Synchronisers: [1] is the synchronised value, [2] the edge-detect stage
  logic [2:0] ncs_sync_q, ncs_sync_d;
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] copi_sync_q, copi_sync_d;

  // Counts clocks since reset so the nCS edge detector only sees genuine pin samples
  logic [1:0] settle_q, settle_d;
  logic       frame_q, frame_d;

  logic [HW-1:0]     hdr_cnt_q, hdr_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              word_done_q, word_done_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [DATA_W-1:0] data_sh_q, data_sh_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  logic              ncs_s, copi_s, sclk_rise, sclk_fall, ncs_fall, active, in_range;
  logic [DATA_W-1:0] word_next, rd_word;

  // Edge detection and the range check for the current address
  always_comb begin
    ncs_s     = ncs_sync_q[1];
    copi_s    = copi_sync_q[1];
    sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    ncs_fall  = ~ncs_sync_q[1] & ncs_sync_q[2];
    active    = frame_q & ~ncs_s;
    in_range  = (32'(cur_addr_q) < NUM_REGS);
    word_next = (data_sh_q << 1) | DATA_W'(copi_s);
    rd_word   = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(cur_addr_q) == i) rd_word = regs_q[i];
    end
  end

  // Next-state logic: frame decode, per-word commit and read shift register
  always_comb begin
    ncs_sync_d  = {ncs_sync_q[1:0], nCS};
    sclk_sync_d = {sclk_sync_q[1:0], SCLK};
    copi_sync_d = {copi_sync_q[0], COPI};
    settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    frame_d     = frame_q;
    hdr_cnt_d   = hdr_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    word_done_d = word_done_q;
    rw_d        = rw_q;
    cur_addr_d  = cur_addr_q;
    data_sh_d   = data_sh_q;
    tx_sh_d     = tx_sh_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;

    // A frame only starts on a real nCS fall, so a reset mid-frame stays idle until nCS cycles
    if (ncs_s) begin
      frame_d = 1'b0;
    end else if (ncs_fall && settle_q == 2'd3) begin
      frame_d = 1'b1;
    end

    if (!active) begin
      hdr_cnt_d   = '0;
      bit_cnt_d   = '0;
      word_done_d = 1'b0;
      rw_d        = 1'b0;
      cur_addr_d  = '0;
      data_sh_d   = '0;
      tx_sh_d     = '0;
    end else begin
      if (sclk_rise) begin
        if (hdr_cnt_q < HW'(HdrBits)) begin
          if (hdr_cnt_q == '0) begin
            rw_d = copi_s;
          end else begin
            cur_addr_d = (cur_addr_q << 1) | ADDR_W'(copi_s);
          end
          hdr_cnt_d = hdr_cnt_q + HW'(1);
        end else if (!word_done_q) begin
          data_sh_d = word_next;
          if (bit_cnt_q == BW'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            if (rw_q && in_range) begin
              for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (32'(cur_addr_q) == i) regs_d[i] = word_next;
              end
              wr_strobe_d = 1'b1;
              wr_addr_d   = cur_addr_q;
            end
`ifdef SPI_BURST_EN
            cur_addr_d = cur_addr_q + ADDR_W'(1);
`else
            word_done_d = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      // Load at each word boundary after the header; once single-word mode is done, shift zeros
      if (sclk_fall) begin
        if (hdr_cnt_q == HW'(HdrBits) && bit_cnt_q == '0 && !word_done_q) begin
          tx_sh_d = in_range ? rd_word : '0;
        end else begin
          tx_sh_d = tx_sh_q << 1;
        end
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ncs_sync_q  <= 3'b111;
      sclk_sync_q <= 3'b000;
      copi_sync_q <= 2'b00;
      settle_q    <= '0;
      frame_q     <= 1'b0;
      hdr_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      word_done_q <= 1'b0;
      rw_q        <= 1'b0;
      cur_addr_q  <= '0;
      data_sh_q   <= '0;
      tx_sh_q     <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      ncs_sync_q  <= ncs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      copi_sync_q <= copi_sync_d;
      settle_q    <= settle_d;
      frame_q     <= frame_d;
      hdr_cnt_q   <= hdr_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      word_done_q <= word_done_d;
      rw_q        <= rw_d;
      cur_addr_q  <= cur_addr_d;
      data_sh_q   <= data_sh_d;
      tx_sh_q     <= tx_sh_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  // Output mapping
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_out[i*DATA_W +: DATA_W] = regs_q[i];
    CIPO      = ~ncs_s & tx_sh_q[DATA_W-1];
    cipo_oe   = ~ncs_s;
    busy      = ~ncs_s;
    wr_strobe = wr_strobe_q;
    wr_addr   = wr_addr_q;
  end

endmodule
